// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_entry_t : one queued fetch, {pc, instr}
//   fetch_state_t : sequencer FSM state (RUN / HALT)
//   PC_STEP       : byte increment between sequential fetches
//   NOP_INSTR     : instruction presented on out_instr when nothing is queued
package fetch_pkg;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: count-based circular queue of fetch_entry_t.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   i_flush          : empty the queue (a concurrent pop is simply absorbed)
//   i_push, i_data   : enqueue an entry; accepted when not full or popping
//   i_pop            : dequeue the head; ignored when empty
//   o_head           : current head entry (valid only when !o_empty)
//   o_empty, o_full  : occupancy flags derived from the entry count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic         o_empty,
  output logic         o_full
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  fetch_entry_t  r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents of empty slots are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer.
// Owns the PC, addresses instruction memory, queues {pc, instr} pairs and
// hands them to decode over a valid/ready handshake. Redirect flushes and
// restarts fetch; halt_req stops new fetches while the queue drains.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   imem_addr / imem_instr     : instruction memory address (= PC) and read data
//   redirect_valid/redirect_pc : flush and restart at word-aligned redirect_pc
//   halt_req                   : level; suppresses fetch and enters HALT
//   out_valid/out_ready        : decode handshake on the queue head
//   out_pc / out_instr         : head entry (NOP instruction when empty)
//   halted                     : high while in HALT
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted
);

  logic [31:0]  r_pc;
  fetch_state_t r_state;
  logic         r_halted;

  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_fetch;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

  assign w_pop       = !w_empty && out_ready;
  assign w_push_data = '{pc: r_pc, instr: imem_instr};

  // Fetch when running, not halting/redirecting, and the queue has (or is freeing) a slot.
  always_comb begin
    w_fetch = 1'b0;
    if ((r_state == RUN) && !halt_req && !redirect_valid && (!w_full || w_pop)) begin
      w_fetch = 1'b1;
    end else begin
      w_fetch = 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_fetch),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // PC and RUN/HALT sequencing; reset beats redirect, redirect beats halt and fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_state  <= RUN;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= align_pc(redirect_pc);
      r_state  <= RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (halt_req) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (w_fetch) begin
            r_pc <= r_pc + PC_STEP;
          end
        end
        HALT: begin
          if (!halt_req) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_pc    = w_head.pc;
  assign out_instr = w_empty ? NOP_INSTR : w_head.instr;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return NOP;
    endcase
  endfunction

  always_comb imem_instr = imem(imem_addr);

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0d: got %h expected %h", name, idx, got, exp);
  endtask

  // Scoreboard: expected entries pushed at fetch time, popped when decode accepts.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  logic        m_halt = 1'b0;

  task automatic model_step(input logic do_chk, input int idx);
    logic pop, fetch;
    ent_t e;
    if (do_chk) begin
      check("sb_valid", idx, 32'(out_valid), 32'(mq.size() != 0));
      check("sb_halted", idx, 32'(halted), 32'(m_halt));
      check("sb_addr", idx, imem_addr, m_pc);
      if (mq.size() != 0) begin
        check("sb_pc", idx, out_pc, mq[0].pc);
        check("sb_instr", idx, out_instr, mq[0].instr);
      end
    end
    pop = (mq.size() != 0) && out_ready;
    if (!rst_n) begin
      mq.delete(); m_pc = 32'h0; m_halt = 1'b0;
    end else if (redirect_valid) begin
      mq.delete(); m_pc = {redirect_pc[31:2], 2'b00}; m_halt = 1'b0;
    end else begin
      fetch = !m_halt && !halt_req && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (fetch) begin
        e.pc = m_pc; e.instr = imem(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      if (!m_halt && halt_req) m_halt = 1'b1;
      else if (m_halt && !halt_req) m_halt = 1'b0;
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic h, input logic rdy);
    @(negedge clk);
    rst_n = r; redirect_valid = rd; redirect_pc = rp; halt_req = h; out_ready = rdy;
    #1;
  endtask

  typedef struct {
    logic rst; logic rd; logic [31:0] rpc; logic hlt; logic rdy; logic chk;
    logic ev; logic [31:0] epc; logic [31:0] ein; logic eh; logic [31:0] ea;
  } vec_t;
  vec_t vt[32];

  initial begin
    //            rst   rd    rpc            hlt   rdy   chk   ev    epc            ein            eh    ea
    vt[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h4};
    vt[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h4,        32'h00A00113, 1'b0, 32'h8};
    vt[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h8,        32'h002081B3, 1'b0, 32'hC};
    vt[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h4};
    vt[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h8};
    vt[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h8};
    vt[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h8};
    vt[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h8};
    vt[12] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h4,        32'h00A00113, 1'b0, 32'hC};
    vt[13] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h8,        32'h002081B3, 1'b0, 32'h10};
    vt[14] = '{1'b1, 1'b1, 32'h103,      1'b0, 1'b0, 1'b1, 1'b1, 32'h8,        32'h002081B3, 1'b0, 32'h10};
    vt[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h100};
    vt[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h100,      NOP,          1'b0, 32'h104};
    vt[17] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h104,      NOP,          1'b0, 32'h108};
    vt[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 32'h108};
    vt[19] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 32'h108};
    vt[20] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 32'h108};
    vt[21] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 32'h108};
    vt[22] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h108};
    vt[23] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h108,      NOP,          1'b0, 32'h10C};
    vt[24] = '{1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10C,      NOP,          1'b0, 32'h110};
    vt[25] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFC};
    vt[26] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, NOP,          1'b0, 32'h0};
    vt[27] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h4};
    vt[28] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h8};
    vt[29] = '{1'b0, 1'b1, 32'h200,      1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h8};
    vt[30] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
    vt[31] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        32'h00500093, 1'b0, 32'h4};

    // Directed sequences: reset/run, backpressure, redirect, halt, wrap, mid-stream reset.
    for (int i = 0; i < 32; i++) begin
      drive(vt[i].rst, vt[i].rd, vt[i].rpc, vt[i].hlt, vt[i].rdy);
      if (vt[i].chk) begin
        check("tbl_valid", i, 32'(out_valid), 32'(vt[i].ev));
        check("tbl_halted", i, 32'(halted), 32'(vt[i].eh));
        check("tbl_addr", i, imem_addr, vt[i].ea);
        if (vt[i].ev) begin
          check("tbl_pc", i, out_pc, vt[i].epc);
          check("tbl_instr", i, out_instr, vt[i].ein);
        end
      end
      model_step(vt[i].chk, i);
    end

    // Randomised traffic checked against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic r, rd, h, rdy;
      logic [31:0] rp;
      r   = ($urandom_range(0, 63) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rp  = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      h   = ($urandom_range(0, 9) < 2);
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, rd, rp, h, rdy);
      model_step(1'b1, 100 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer for the 5-stage core. Owns the program counter, drives the address port of `instruction_memory`, and buffers fetched words in a small queue. Presents fetched words to the decode stage through a valid/ready handshake. Handles control-flow redirects (branch, jump, flush) and a halt request.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, 2: fetch-queue entries; power of two, ≥ 2.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `imem_addr`  out  32: byte address to `instruction_memory`; equals the current PC.
- `imem_instr`  in  32: combinational instruction for `imem_addr`, valid in the same cycle.
- `redirect_valid`  in  1: flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: target address; bits [1:0] are ignored and forced to 0.
- `halt_req`  in  1: level; while high, no new fetches are issued.
- `out_valid`  out  1: queue head is valid.
- `out_ready`  in  1: decode accepts the head.
- `out_pc`  out  32: PC of the head entry.
- `out_instr`  out  32: instruction of the head entry.
- `halted`  out  1: high while the FSM is in HALT.

## Operation
- FSM states are RUN and HALT; reset enters RUN.
  - RUN→HALT when `halt_req`=1 and `redirect_valid`=0.
  - HALT→RUN when `halt_req`=0, or when `redirect_valid`=1 (the redirect is applied).
  - `halted` = (state==HALT).
- Fetch condition: state RUN, `halt_req`=0, `redirect_valid`=0, and the queue has space. "Has space" means not full, or full with a pop in the same cycle.
- On fetch: push {PC, `imem_instr`} to the queue and set PC ← PC+4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Pop occurs when `out_valid` && `out_ready`.
- Redirect takes priority over everything:
  - The queue is emptied and PC ← {`redirect_pc`[31:2], 2'b00}.
  - There is no push that cycle.
  - A pop in the same cycle still counts as accepted by decode.
- `halt_req` does not flush the queue; buffered entries continue to drain to decode.
- When the queue is empty, `out_pc` and `out_instr` are don't-care, and `out_valid`=0.
- Entries leave the queue in order; an entry is never duplicated or dropped except by redirect.

## Timing
- Reset values: PC=`RESET_PC`, queue empty, `out_valid`=0, `halted`=0, `imem_addr`=`RESET_PC`.
- If reset is asserted mid-operation, it overrides redirect and halt in the same edge.
- Fetch-to-output latency is 1 cycle: a word fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- Steady-state throughput is 1 instruction per cycle with `out_ready` held high, and the queue holds at most 1 entry.
- Backpressure:
  - With `out_ready`=0, the queue fills after `FIFO_DEPTH` fetches; fetch then stops and PC holds.
  - The cycle `out_ready` rises, one pop and one push occur together, so there is no bubble.
- Redirect timing:
  - Asserted in cycle N: `out_valid`=0 in N+1.
  - Fetch of the target happens in N+1.
  - Target appears at the head in N+2.
- `imem_addr` changes only on a clock edge, never combinationally from inputs.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}.
  - `PC_STEP`=4.
  - `NOP_INSTR`=32'h0000_0013.
  - FSM enum `fetch_state_t` {RUN, HALT}.
- Sub-module `fetch_fifo`:
  - Parameterised by `FIFO_DEPTH`, stores `fetch_entry_t`.
  - Synchronous active-low reset, flush input, simultaneous push/pop when full.
  - Count-based full/empty with pointer wrap-around.
- `fetch_unit` instantiates `fetch_fifo`; the core top connects `imem_addr`/`imem_instr` to `instruction_memory`.

## Test plan
- **Reset then run:** memory 00500093, 00A00113, 002081B3; `out_ready`=1 → head sequence (0,00500093), (4,00A00113), (8,002081B3) on consecutive cycles starting 1 cycle after reset release.
- **Backpressure:** hold `out_ready`=0 for 5 cycles → exactly 2 entries buffered, PC=8, `imem_addr` stable at 8. Release → PCs 0, 4, 8 delivered with no gap or duplicate.
- **Redirect with full queue:** `redirect_valid`=1, `redirect_pc`=32'h0000_0103 → `out_valid`=0 next cycle. Then head is PC 32'h100 with instr 00000013 (unloaded NOP fill).
- **Halt:** assert `halt_req` for 4 cycles with `out_ready`=1 → buffered entries drain, `halted`=1, PC frozen. Deassert → fetch resumes at the frozen PC.
- **Wrap:** `redirect_pc`=32'hFFFF_FFFC → heads at PC FFFF_FFFC then 0000_0000.
- **Reset mid-stream:** pulse `rst_n`=0 for 1 cycle while the queue is full → next cycle `out_valid`=0, PC=`RESET_PC`, `halted`=0.
